bus_mux_reg: RTL and testbench
==============================

BUS_MUX_REG -- requirements
Module: bus_mux_reg

Interface
REQ-001 Parameter WIDTH, default 16: bus and per-source data width in bits.
REQ-002 Parameter NSRC, default 10: number of bus sources, ordered R0..R7, DIN, G; NSRC >= 2.
REQ-003 Parameter SELW, default 4: width of bus_src, equal to ceil(log2(NSRC)).
REQ-004 Clock  in  1: single clock; all state updates on its rising edge.
REQ-005 Reset  in  1: reset, synchronous and active-high.
REQ-006 sel  in  NSRC: one-hot source select; bit i drives source i; all zero means no driver.
REQ-007 src_data  in  NSRC*WIDTH: packed source data; source i occupies bits [i*WIDTH +: WIDTH].
REQ-008 clr_err  in  1: clears the conflict flag and the conflict counter.
REQ-009 BusWires  out  WIDTH: registered bus value.
REQ-010 bus_valid  out  1: BusWires was loaded from a source in the previous cycle.
REQ-011 bus_src  out  SELW: index of the source loaded into BusWires.
REQ-012 conflict  out  1: sticky flag, set when sel had two or more bits set.
REQ-013 conflict_cnt  out  8: saturating count of conflict cycles.

Function
REQ-014 Edge with sel non-zero: BusWires <= data of winning source; bus_valid <= 1; bus_src <= winner index.
REQ-015 Winner is the lowest set index of sel; one-hot sel selects its only set bit.
REQ-016 Latency: data sampled at edge N appears on BusWires after edge N; one cycle, no combinational path from src_data or sel to any output.
REQ-017 Edge with sel all zero: BusWires and bus_src hold their previous values; bus_valid <= 0.
REQ-018 BusWires never goes X or Z from the select logic; an undriven bus holds its value.
REQ-019 Edge with two or more sel bits set: the lowest-index winner is still loaded per REQ-014, and conflict <= 1.
REQ-020 conflict stays 1 until a clr_err edge or a reset.
REQ-021 conflict_cnt increments by 1 on each conflict edge and saturates at 255; it never wraps.
REQ-022 clr_err and a conflict in the same edge: the conflict wins; conflict = 1 and conflict_cnt = 1 after the edge.
REQ-023 clr_err alone: conflict <= 0 and conflict_cnt <= 0; BusWires, bus_valid and bus_src follow REQ-014/REQ-017 unaffected.
REQ-024 Source i data changing while sel[i] stays 1: every edge reloads BusWires, tracking the new data one cycle later.
REQ-025 Bits of sel at index >= NSRC do not exist; src_data bits outside NSRC*WIDTH do not exist.

Reset
REQ-026 Reset = 1 at an edge: BusWires <= 0, bus_valid <= 0, bus_src <= 0, conflict <= 0, conflict_cnt <= 0.
REQ-027 Reset has priority over sel and clr_err in the same edge; asserting it mid-transfer discards the pending load.
REQ-028 First edge after Reset deasserts: normal operation per REQ-014..REQ-024.

Configuration
REQ-029 Macro BUS_MUX_REG_CONFLICT_CNT_EN defined: the conflict_cnt counter is built and behaves per REQ-021..REQ-023.
REQ-030 Macro BUS_MUX_REG_CONFLICT_CNT_EN undefined: no counter register; conflict_cnt is tied to 0; conflict flag still built and functional.

Verification
REQ-031 Reset, then sel=0000000001, R0=16'h1234 -> after 1 edge BusWires=16'h1234, bus_valid=1, bus_src=0.
REQ-032 sel=1000000000, G=16'hBEEF, then sel=0 for 3 edges -> BusWires holds 16'hBEEF, bus_valid=0, bus_src=9.
REQ-033 sel=0000100100 (R2=16'h0002, R5=16'h0005) -> BusWires=16'h0002, bus_src=2, conflict=1, conflict_cnt=1.
REQ-034 300 consecutive conflict edges -> conflict_cnt=255 after edge 255 onward; then clr_err alone -> conflict=0, conflict_cnt=0.
REQ-035 clr_err=1 with a conflicting sel in the same edge -> conflict=1, conflict_cnt=1; macro undefined -> conflict_cnt=0 throughout.
REQ-036 Reset=1 with sel=0100000000, DIN=16'hFFFF -> BusWires=0, bus_valid=0; next edge with Reset=0 -> BusWires=16'hFFFF, bus_src=8.

Source files
------------

// File: rtl/bus_mux_reg.sv
// bus_mux_reg: registered one-hot bus multiplexer (sources R0..R7, DIN, G).
// The lowest-index selected source wins; multiple selects raise a sticky
// conflict flag. Optional saturating conflict counter is built only when
// BUS_MUX_REG_CONFLICT_CNT_EN is defined; otherwise conflict_cnt reads 0.
module bus_mux_reg #(
    parameter int WIDTH = 16,
    parameter int NSRC  = 10,
    parameter int SELW  = 4
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [NSRC-1:0]       sel,
    input  logic [NSRC*WIDTH-1:0] src_data,
    input  logic                  clr_err,
    output logic [WIDTH-1:0]      BusWires,
    output logic                  bus_valid,
    output logic [SELW-1:0]       bus_src,
    output logic                  conflict,
    output logic [7:0]            conflict_cnt
);

    logic             hit;
    logic [SELW-1:0]  win_idx;
    logic [WIDTH-1:0] win_data;
    logic             multi;

    // Priority select: scan high to low so the lowest set index is the last write.
    always_comb begin
        hit      = 1'b0;
        win_idx  = '0;
        win_data = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (sel[i]) begin
                hit      = 1'b1;
                win_idx  = SELW'(i);
                win_data = src_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Two or more bits set iff clearing the lowest set bit leaves something.
    assign multi = |(sel & (sel - {{(NSRC-1){1'b0}}, 1'b1}));

    // Bus register: load the winner, hold value and source when undriven.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            BusWires  <= '0;
            bus_valid <= 1'b0;
            bus_src   <= '0;
        end else begin
            bus_valid <= hit;
            if (hit) begin
                BusWires <= win_data;
                bus_src  <= win_idx;
            end
        end
    end

    // Sticky conflict flag; a conflict in the same edge beats the clear.
    always_ff @(posedge Clock) begin
        if (Reset)
            conflict <= 1'b0;
        else if (multi)
            conflict <= 1'b1;
        else if (clr_err)
            conflict <= 1'b0;
    end

`ifdef BUS_MUX_REG_CONFLICT_CNT_EN
    // Saturating conflict counter; clear plus conflict restarts the count at 1.
    always_ff @(posedge Clock) begin
        if (Reset)
            conflict_cnt <= '0;
        else if (multi) begin
            if (clr_err)
                conflict_cnt <= 8'd1;
            else if (conflict_cnt != 8'hFF)
                conflict_cnt <= conflict_cnt + 8'd1;
        end else if (clr_err)
            conflict_cnt <= '0;
    end
`else
    assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_bus_mux_reg.sv
// Directed testbench for bus_mux_reg: vector table plus saturation,
// data-tracking and no-combinational-path sequences.
module tb_bus_mux_reg;

    localparam int WIDTH = 16;
    localparam int NSRC  = 10;
    localparam int SELW  = 4;
`ifdef BUS_MUX_REG_CONFLICT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic                  Clock = 1'b0;
    logic                  Reset;
    logic [NSRC-1:0]       sel;
    logic [NSRC*WIDTH-1:0] src_data;
    logic                  clr_err;
    logic [WIDTH-1:0]      BusWires;
    logic                  bus_valid;
    logic [SELW-1:0]       bus_src;
    logic                  conflict;
    logic [7:0]            conflict_cnt;

    int checks = 0;
    int errors = 0;

    bus_mux_reg #(.WIDTH(WIDTH), .NSRC(NSRC), .SELW(SELW)) dut (
        .Clock(Clock), .Reset(Reset), .sel(sel), .src_data(src_data),
        .clr_err(clr_err), .BusWires(BusWires), .bus_valid(bus_valid),
        .bus_src(bus_src), .conflict(conflict), .conflict_cnt(conflict_cnt)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic            rst;
        logic            clr;
        logic [9:0]      s;
        int              ovi;   // source index whose data is overridden, -1 none
        logic [15:0]     ovv;
        logic [15:0]     e_bus;
        logic            e_vld;
        logic [3:0]      e_src;
        logic            e_cf;
        logic [7:0]      e_cnt; // expected with counter built
    } vec_t;

    vec_t vt[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Default data: source i carries value i; optionally override one source.
    task automatic set_src(input int ovi, input logic [15:0] ovv);
        for (int i = 0; i < NSRC; i++)
            src_data[i*WIDTH +: WIDTH] = (i == ovi) ? ovv : 16'(i);
    endtask

    task automatic chk_all(input string tag, input logic [15:0] eb, input logic ev,
                           input logic [3:0] es, input logic ec, input logic [7:0] en);
        chk({tag, ".bus"},   32'(BusWires),     32'(eb));
        chk({tag, ".valid"}, 32'(bus_valid),    32'(ev));
        chk({tag, ".src"},   32'(bus_src),      32'(es));
        chk({tag, ".cf"},    32'(conflict),     32'(ec));
        chk({tag, ".cnt"},   32'(conflict_cnt), CNT_EN ? 32'(en) : 32'd0);
    endtask

    initial begin
        //        rst  clr  sel            ovi ovv       bus       vld src  cf cnt
        vt[0]  = '{1'b1,1'b0,10'b0000000000,-1,16'h0000,16'h0000,1'b0,4'd0,1'b0,8'd0};
        vt[1]  = '{1'b0,1'b0,10'b0000000001, 0,16'h1234,16'h1234,1'b1,4'd0,1'b0,8'd0};
        vt[2]  = '{1'b0,1'b0,10'b1000000000, 9,16'hBEEF,16'hBEEF,1'b1,4'd9,1'b0,8'd0};
        vt[3]  = '{1'b0,1'b0,10'b0000000000,-1,16'h0000,16'hBEEF,1'b0,4'd9,1'b0,8'd0};
        vt[4]  = '{1'b0,1'b0,10'b0000000000,-1,16'h0000,16'hBEEF,1'b0,4'd9,1'b0,8'd0};
        vt[5]  = '{1'b0,1'b0,10'b0000000000,-1,16'h0000,16'hBEEF,1'b0,4'd9,1'b0,8'd0};
        vt[6]  = '{1'b0,1'b0,10'b0000100100,-1,16'h0000,16'h0002,1'b1,4'd2,1'b1,8'd1};
        vt[7]  = '{1'b0,1'b0,10'b0000100000,-1,16'h0000,16'h0005,1'b1,4'd5,1'b1,8'd1};
        vt[8]  = '{1'b0,1'b1,10'b0000000100,-1,16'h0000,16'h0002,1'b1,4'd2,1'b0,8'd0};
        vt[9]  = '{1'b0,1'b1,10'b0000000110,-1,16'h0000,16'h0001,1'b1,4'd1,1'b1,8'd1};
        vt[10] = '{1'b0,1'b0,10'b0000000000,-1,16'h0000,16'h0001,1'b0,4'd1,1'b1,8'd1};
        vt[11] = '{1'b1,1'b0,10'b0100000000, 8,16'hFFFF,16'h0000,1'b0,4'd0,1'b0,8'd0};
        vt[12] = '{1'b0,1'b0,10'b0100000000, 8,16'hFFFF,16'hFFFF,1'b1,4'd8,1'b0,8'd0};
        vt[13] = '{1'b0,1'b0,10'b1100000000, 8,16'hFFFF,16'hFFFF,1'b1,4'd8,1'b1,8'd1};
        vt[14] = '{1'b1,1'b1,10'b1111111111,-1,16'h0000,16'h0000,1'b0,4'd0,1'b0,8'd0};

        Reset = 1'b1; clr_err = 1'b0; sel = '0; set_src(-1, 16'h0);
        @(posedge Clock); #1;

        for (int v = 0; v < 15; v++) begin
            Reset = vt[v].rst; clr_err = vt[v].clr; sel = vt[v].s;
            set_src(vt[v].ovi, vt[v].ovv);
            @(posedge Clock); #1;
            chk_all($sformatf("vec%0d", v), vt[v].e_bus, vt[v].e_vld,
                    vt[v].e_src, vt[v].e_cf, vt[v].e_cnt);
        end

        // Source data changing under a steady select: bus tracks one edge later.
        Reset = 1'b0; clr_err = 1'b0; sel = 10'b0000001000;
        for (int k = 0; k < 3; k++) begin
            set_src(3, 16'h3000 + 16'(k));
            @(posedge Clock); #1;
            chk($sformatf("track%0d.bus", k), 32'(BusWires), 32'(16'h3000 + 16'(k)));
        end

        // No combinational path: new inputs between edges leave outputs alone.
        sel = 10'b1000000011; set_src(9, 16'h5A5A); #2;
        chk("comb.bus", 32'(BusWires), 32'h3002);
        chk("comb.src", 32'(bus_src), 32'd3);
        chk("comb.cf",  32'(conflict), 32'd0);

        // 300 conflict edges: counter saturates at 255 without wrapping.
        sel = 10'b1111111111; set_src(-1, 16'h0);
        for (int n = 1; n <= 300; n++) begin
            @(posedge Clock); #1;
            if (n == 1 || n == 254 || n == 255 || n == 256 || n == 300) begin
                chk($sformatf("sat%0d.cnt", n), 32'(conflict_cnt),
                    CNT_EN ? ((n > 255) ? 32'd255 : 32'(n)) : 32'd0);
                chk($sformatf("sat%0d.cf", n), 32'(conflict), 32'd1);
            end
        end
        chk("sat.bus", 32'(BusWires), 32'h0000);
        chk("sat.src", 32'(bus_src), 32'd0);

        // clr_err alone clears flag and counter; bus holds with no driver.
        sel = '0; clr_err = 1'b1;
        @(posedge Clock); #1;
        chk_all("clr", 16'h0000, 1'b0, 4'd0, 1'b0, 8'd0);
        clr_err = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
